pixel_collect3: RTL
===================

# pixel_collect3

Downstream companion of the three-engine coordinate distributor. It accepts one result per engine (engines 0, 1 and 2 correspond to coordinates x1/y1, x2/y2 and x3/y3 of a batch) and buffers the batch of three. It then pulses `fin_flag` back to the distributor and emits the three pixels in raster order on a valid/ready stream, with start-of-frame and end-of-frame markers.

## Interface
- `PIXEL_DATA_WIDTH`, default 32: width of each engine result and of `out_data`.
- `SCREEN_WIDTH`, default 640: pixels per line.
- `SCREEN_HEIGHT`, default 480: lines per frame.
- `NUM_ENGINES`, fixed at 3: engines per batch. `SCREEN_WIDTH*SCREEN_HEIGHT` must be a multiple of 3.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `in_valid` in 3: bit i set means engine i presents a result; held until accepted.
- `in_data0`, `in_data1`, `in_data2` in `PIXEL_DATA_WIDTH` each: engine results.
- `in_ready` out 3: bit i set means engine i's result is accepted this cycle if `in_valid[i]` is high.
- `fin_flag` out 1: one-cycle pulse to the distributor to advance to the next batch.
- `out_valid` out 1: an output pixel is available.
- `out_ready` in 1: downstream accepts the pixel.
- `out_data` out `PIXEL_DATA_WIDTH`: pixel result.
- `out_sop` out 1: qualified by `out_valid`; marks frame pixel 0.
- `out_eop` out 1: qualified by `out_valid`; marks frame pixel `W*H-1`.

## Operation
- FSM states:
  - COLLECT: gather results.
  - EMIT: stream the buffered batch.
- Registers:
  - `captured[2:0]`: sticky per-engine flags.
  - `buf0..buf2`: result buffers.
  - `idx`: 0..2, position within the batch.
  - `pix_count`: 0..`W*H-1`, with width ceil(log2(`W*H`)).
- `in_ready[i] = (state==COLLECT) & ~captured[i]`, combinational. It is forced to 0 while `reset_n` is low.
- COLLECT:
  - Each accepted `in_valid[i] & in_ready[i]` loads `buf_i` and sets `captured[i]`.
  - Any subset of engines may be accepted in the same cycle, including all three.
  - Arrival order is irrelevant; emission order is always engine 0, 1, 2.
- COLLECT -> EMIT: on the edge where `captured | accepted == 3'b111`. On that edge, `captured` is cleared and `idx` is set to 0.
- EMIT:
  - `out_valid = 1`; `out_data = buf[idx]`.
  - `out_sop = (pix_count==0)`; `out_eop = (pix_count==W*H-1)`.
  - On each `out_valid & out_ready`: `idx` increments, and `pix_count` increments, wrapping `W*H-1` -> 0.
- EMIT -> COLLECT: on the handshake with `idx==2`.
- Backpressure: while `out_ready` is low, `out_data`, `out_sop` and `out_eop` hold stable. No pixel is dropped or duplicated.
- Engine results presented during EMIT wait, because `in_ready` is 0. No data is lost.

## Timing
- Reset state (asynchronous, immediate): state COLLECT, `captured=0`, `idx=0`, `pix_count=0`, `fin_flag=0`, `out_valid=0`, `out_sop=0`, `out_eop=0`, `out_data=0`.
- `fin_flag` is registered. It is high for exactly the first EMIT cycle, i.e. the cycle after the final capture edge. The distributor sees it at its next edge.
- Latency: first output pixel is valid the cycle after the final capture edge, at the same time as `fin_flag`.
- With `out_ready=1`, the three pixels appear on three consecutive cycles.
- Minimum batch period: 4 cycles (1 COLLECT cycle + 3 EMIT cycles).
- `in_ready` returns to 3'b111 in the cycle after the third output handshake.
- Reset during EMIT or part-way through COLLECT:
  - The buffered batch or partial batch is discarded.
  - `out_valid` falls immediately.
  - The next emitted pixel carries `out_sop`.
- Frame wrap: after the `out_eop` handshake, the next pixel has `out_sop`. There is no idle gap beyond the normal batch cadence.

## Test plan
- Reset: hold `reset_n` low mid-stream -> all outputs 0 asynchronously, `in_ready=000`. After release: `in_ready=111`, `out_valid=0`.
- Simultaneous capture: `in_valid=111` with data 10/20/30 and `out_ready=1` -> the next cycles show:
  - `fin_flag` high for 1 cycle;
  - `out_data` 10, 20, 30 on 3 consecutive cycles;
  - `out_sop` on 10 only;
  - `in_ready=000` during emission.
- Staggered engines: engine 2 valid at cycle 0, engine 0 at cycle 3, engine 1 at cycle 5 -> each engine's `in_ready` drops after its capture. EMIT starts at cycle 6 and order is still engine 0, 1, 2.
- Backpressure: `out_ready` low for 4 cycles while the second pixel is presented -> `out_data` holds that value. Exactly 3 handshakes occur per batch, and `fin_flag` pulses once.
- Frame wrap with `SCREEN_WIDTH=6`, `SCREEN_HEIGHT=2`: 5 back-to-back batches ->
  - `out_eop` only on the 12th pixel;
  - `out_sop` on the 1st and 13th pixels.
- Reset mid-EMIT after 1 pixel has been emitted -> `out_valid` drops at once. The next full batch is emitted from `pix_count=0` with `out_sop`.

Source files
------------

// File: rtl/pixel_collect3.sv
// Collects one result from each of three engines, then streams the batch in
// engine order with start/end-of-frame markers and a batch-advance pulse.
module pixel_collect3 #(
   parameter int PIXEL_DATA_WIDTH = 32,
   parameter int SCREEN_WIDTH     = 640,
   parameter int SCREEN_HEIGHT    = 480,
   parameter int NUM_ENGINES      = 3
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_ENGINES-1:0]      in_valid,
   input  logic [PIXEL_DATA_WIDTH-1:0] in_data0,
   input  logic [PIXEL_DATA_WIDTH-1:0] in_data1,
   input  logic [PIXEL_DATA_WIDTH-1:0] in_data2,
   output logic [NUM_ENGINES-1:0]      in_ready,
   output logic                        fin_flag,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [PIXEL_DATA_WIDTH-1:0] out_data,
   output logic                        out_sop,
   output logic                        out_eop
);

   localparam int FRAME_PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;
   localparam int PIX_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIXELS - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_t;

   state_t                      state;
   logic [2:0]                  captured;
   logic [2:0]                  accepted;
   logic                        batch_done;
   logic [1:0]                  idx;
   logic [PIX_W-1:0]            pix_count;
   logic [PIX_W-1:0]            pix_next;
   logic [PIXEL_DATA_WIDTH-1:0] buf0;
   logic [PIXEL_DATA_WIDTH-1:0] buf1;
   logic [PIXEL_DATA_WIDTH-1:0] buf2;
   logic [PIXEL_DATA_WIDTH-1:0] first_data;
   logic [PIXEL_DATA_WIDTH-1:0] next_data;

   // Ready is gated by reset_n so engines never see a handshake during reset.
   assign in_ready   = {3{reset_n & (state == COLLECT)}} & ~captured;
   assign accepted   = in_valid & in_ready;
   assign batch_done = (state == COLLECT) && ((captured | accepted) == 3'b111);
   assign pix_next   = (pix_count == LAST_PIX) ? '0 : pix_count + 1'b1;

   // Engine 0 may be captured on the same edge that completes the batch.
   assign first_data = accepted[0] ? in_data0 : buf0;

   // NOTE: always_comb with a default first keeps this mux free of latches.
   always_comb begin
      next_data = buf2;
      if (idx == 2'd0) next_data = buf1;
   end

   // NOTE: result buffers carry no reset; captured[] alone decides validity.
   always_ff @(posedge clk) begin
      if (accepted[0]) buf0 <= in_data0;
      if (accepted[1]) buf1 <= in_data1;
      if (accepted[2]) buf2 <= in_data2;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= COLLECT;
         captured  <= '0;
         idx       <= '0;
         pix_count <= '0;
         fin_flag  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
      end else begin
         fin_flag <= 1'b0;
         case (state)
            COLLECT: begin
               captured <= captured | accepted;
               if (batch_done) begin
                  state     <= EMIT;
                  captured  <= '0;
                  idx       <= '0;
                  fin_flag  <= 1'b1;
                  out_valid <= 1'b1;
                  out_data  <= first_data;
                  out_sop   <= (pix_count == '0);
                  out_eop   <= (pix_count == LAST_PIX);
               end
            end
            EMIT: begin
               if (out_ready) begin
                  pix_count <= pix_next;
                  if (idx == 2'd2) begin
                     state     <= COLLECT;
                     idx       <= '0;
                     out_valid <= 1'b0;
                     out_data  <= '0;
                     out_sop   <= 1'b0;
                     out_eop   <= 1'b0;
                  end else begin
                     idx      <= idx + 2'd1;
                     out_data <= next_data;
                     out_sop  <= (pix_next == '0);
                     out_eop  <= (pix_next == LAST_PIX);
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule
